// File: rtl/window55_linebuf.sv
// rtl/window55_linebuf.sv - streaming 5x5 sliding-window generator with four cascaded line buffers
module window55_linebuf #(
    parameter int IMAGE_COLS = 32,
    parameter int IMAGE_ROWS = 32,
    parameter int IN_WIDTH   = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pixel_valid,
    input  logic                         sof,
    input  logic signed [IN_WIDTH-1:0]   nextPixel,
    output logic [25*IN_WIDTH-1:0]       win_flat,
    output logic                         window_valid,
    output logic                         frame_done
);

    localparam int CW = (IMAGE_COLS > 1) ? $clog2(IMAGE_COLS) : 1;
    localparam int RW = (IMAGE_ROWS > 1) ? $clog2(IMAGE_ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_ROWS - 1);
    localparam logic [CW-1:0] COL_EDGE = CW'(4);
    localparam logic [RW-1:0] ROW_EDGE = RW'(4);

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [CW-1:0]         eff_col;
    logic [RW-1:0]         eff_row;
    logic                  accept;
    logic                  at_row_end;
    logic                  at_frame_end;
    logic                  interior;

    logic [IN_WIDTH-1:0]   lb [4][IMAGE_COLS];
    logic [IN_WIDTH-1:0]   lb_out [4];
    logic [IN_WIDTH-1:0]   new_col [5];
    logic [IN_WIDTH-1:0]   win [5][5];

    // A start-of-frame pixel is always treated as position (0,0), whatever the counters say.
    always_comb begin
        accept       = pixel_valid;
        eff_col      = (pixel_valid && sof) ? '0 : col;
        eff_row      = (pixel_valid && sof) ? '0 : row;
        at_row_end   = (eff_col == COL_LAST);
        at_frame_end = at_row_end && (eff_row == ROW_LAST);
        interior     = (eff_row >= ROW_EDGE) && (eff_col >= COL_EDGE);
    end

    // Line-buffer read port: entry at the current column holds the pixel from 1..4 rows above.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lb_out[k] = lb[k][eff_col];
        end
        new_col[0] = lb_out[3];
        new_col[1] = lb_out[2];
        new_col[2] = lb_out[1];
        new_col[3] = lb_out[0];
        new_col[4] = nextPixel;
    end

    // Line-buffer cascade: new pixel into LB0, each buffer's old entry moves down one buffer.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][eff_col] <= nextPixel;
            for (int k = 1; k < 4; k++) begin
                lb[k][eff_col] <= lb[k-1][eff_col];
            end
        end
    end

    // Raster position counters for the next accepted pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (at_row_end) begin
                col <= '0;
                row <= at_frame_end ? '0 : eff_row + RW'(1);
            end else begin
                col <= eff_col + CW'(1);
                row <= eff_row;
            end
        end
    end

    // Window register: shift one column left and load the new column at c=4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][4] <= new_col[r];
            end
        end
    end

    // Strobes are single-cycle and only follow an accepted pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= accept && interior;
            frame_done   <= accept && at_frame_end;
        end
    end

    // Flatten the window, element (r,c) at index r*5+c.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                win_flat[(r*5+c)*IN_WIDTH +: IN_WIDTH] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_window55_linebuf.sv
// tb/tb_window55_linebuf.sv - self-checking bench for window55_linebuf
module tb_window55_linebuf;

    localparam int COLS = 32;
    localparam int ROWS = 32;
    localparam int W    = 6;
    localparam int NWIN = (ROWS - 4) * (COLS - 4);

    logic                 clk;
    logic                 rst;
    logic                 pixel_valid;
    logic                 sof;
    logic signed [W-1:0]  nextPixel;
    logic [25*W-1:0]      win_flat;
    logic                 window_valid;
    logic                 frame_done;

    int checks   = 0;
    int failures = 0;

    int wv_err, fd_err, win_err, pulses, fds, fd_at_pulse, first_pulse, n_acc;
    int total_pulses = 0;

    typedef struct {
        bit                  v;
        bit                  s;
        logic signed [W-1:0] p;
        bit                  ewv;
        bit                  efd;
        logic signed [W-1:0] e44;
        logic signed [W-1:0] e43;
    } vec_t;

    vec_t vecs [6];

    window55_linebuf #(.IMAGE_COLS(COLS), .IMAGE_ROWS(ROWS), .IN_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_valid  (pixel_valid),
        .sof          (sof),
        .nextPixel    (nextPixel),
        .win_flat     (win_flat),
        .window_valid (window_valid),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic signed [W-1:0] pix(input int pat, input int r, input int c);
        int v;
        case (pat)
            0:       v = ((r*32 + c) % 32) - 16;
            1:       v = ((r*7 + c*3 + 5) % 64) - 32;
            2:       v = ((r*13 + c*5 + 17) % 64) - 32;
            3:       v = -32;
            default: v = 31;
        endcase
        return W'(v);
    endfunction

    function automatic logic signed [W-1:0] field(input int r, input int c);
        return $signed(win_flat[(r*5+c)*W +: W]);
    endfunction

    // One input cycle; outputs are checked #1 after the edge that consumed it.
    task automatic step(input bit v, input bit s, input int pat, input int r, input int c);
        bit exp_wv, exp_fd;
        pixel_valid = v;
        sof         = s;
        nextPixel   = v ? pix(pat, r, c) : W'($urandom);
        @(posedge clk);
        #1;
        exp_wv = v && (r >= 4) && (c >= 4);
        exp_fd = v && (r == ROWS-1) && (c == COLS-1);
        if (v) n_acc++;
        if (window_valid !== exp_wv) wv_err++;
        if (frame_done !== exp_fd) fd_err++;
        if (window_valid === 1'b1) begin
            pulses++;
            total_pulses++;
            if (first_pulse == 0) first_pulse = n_acc;
        end
        if (frame_done === 1'b1) begin
            fds++;
            fd_at_pulse = pulses;
        end
        if (exp_wv) begin
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    if (field(i, j) !== pix(pat, r-4+i, c-4+j)) win_err++;
        end
        pixel_valid = 1'b0;
        sof         = 1'b0;
    endtask

    task automatic run_pixels(input int pat, input bit start_sof, input int npix, input int pct);
        wv_err = 0; fd_err = 0; win_err = 0; pulses = 0; fds = 0;
        fd_at_pulse = 0; first_pulse = 0; n_acc = 0;
        for (int idx = 0; idx < npix; idx++) begin
            while (pct < 100 && $urandom_range(99) >= pct)
                step(1'b0, 1'($urandom_range(1)), pat, idx / COLS, idx % COLS);
            step(1'b1, start_sof && idx == 0, pat, idx / COLS, idx % COLS);
        end
    endtask

    task automatic check_run(input string name, input bit full);
        chk({name, "_valid_pattern_errs"}, wv_err, 0);
        chk({name, "_frame_done_errs"}, fd_err, 0);
        chk({name, "_window_errs"}, win_err, 0);
        if (full) begin
            chk({name, "_pulses"}, pulses, NWIN);
            chk({name, "_frame_done_count"}, fds, 1);
            chk({name, "_frame_done_at_pulse"}, fd_at_pulse, NWIN);
            chk({name, "_first_pulse_pixel"}, first_pulse, 4*COLS + 5);
        end
    endtask

    initial begin
        // w44 is the last accepted pixel, w43 the one before; idle and lone sof cycles hold.
        vecs[0] = '{1'b1, 1'b0,   6'sd5, 1'b0, 1'b0,   6'sd5,   6'sd0};
        vecs[1] = '{1'b0, 1'b0,   6'sd9, 1'b0, 1'b0,   6'sd5,   6'sd0};
        vecs[2] = '{1'b1, 1'b1,  -6'sd3, 1'b0, 1'b0,  -6'sd3,   6'sd5};
        vecs[3] = '{1'b0, 1'b1,   6'sd7, 1'b0, 1'b0,  -6'sd3,   6'sd5};
        vecs[4] = '{1'b1, 1'b0,  6'sd31, 1'b0, 1'b0,  6'sd31,  -6'sd3};
        vecs[5] = '{1'b1, 1'b0, -6'sd32, 1'b0, 1'b0, -6'sd32,  6'sd31};

        rst = 1'b0; pixel_valid = 1'b0; sof = 1'b0; nextPixel = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_win_zero", int'(win_flat == '0), 1);
        chk("reset_window_valid", int'(window_valid), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            pixel_valid = vecs[i].v;
            sof         = vecs[i].s;
            nextPixel   = vecs[i].p;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_window_valid", i), int'(window_valid), int'(vecs[i].ewv));
            chk($sformatf("vec%0d_frame_done", i), int'(frame_done), int'(vecs[i].efd));
            chk($sformatf("vec%0d_w44", i), int'(field(4, 4)), int'(vecs[i].e44));
            chk($sformatf("vec%0d_w43", i), int'(field(4, 3)), int'(vecs[i].e43));
        end
        pixel_valid = 1'b0; sof = 1'b0;

        // Fresh reset, then the basic continuous frame.
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_pixels(0, 1'b0, ROWS*COLS, 100);
        check_run("cont", 1'b1);

        run_pixels(0, 1'b0, ROWS*COLS, 50);
        check_run("gappy", 1'b1);

        // Two back-to-back frames with different content.
        total_pulses = 0;
        run_pixels(1, 1'b0, ROWS*COLS, 100);
        check_run("b2b_a", 1'b1);
        run_pixels(2, 1'b0, ROWS*COLS, 100);
        check_run("b2b_b", 1'b1);
        chk("b2b_total_pulses", total_pulses, 2*NWIN);

        // sof arriving at (10,7) restarts the counters.
        run_pixels(1, 1'b0, 10*COLS + 7, 100);
        check_run("pre_sof", 1'b0);
        run_pixels(2, 1'b1, ROWS*COLS, 100);
        check_run("sof_restart", 1'b1);

        // Reset pulled for one cycle at (20,15); outputs must clear asynchronously.
        run_pixels(2, 1'b0, 20*COLS + 15, 100);
        check_run("pre_rst", 1'b0);
        chk("pre_rst_valid_high", int'(window_valid), 1);
        rst = 1'b0;
        #1;
        chk("midrst_win_zero", int'(win_flat == '0), 1);
        chk("midrst_window_valid", int'(window_valid), 0);
        chk("midrst_frame_done", int'(frame_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_pixels(1, 1'b0, ROWS*COLS, 100);
        check_run("post_rst", 1'b1);

        // Extreme values.
        run_pixels(3, 1'b0, ROWS*COLS, 100);
        check_run("all_neg", 1'b1);
        chk("all_neg_w00", int'(field(0, 0)), -32);
        run_pixels(4, 1'b0, ROWS*COLS, 100);
        check_run("all_pos", 1'b1);
        chk("all_pos_w22", int'(field(2, 2)), 31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window55_linebuf.md
# window55_linebuf

Streaming 5x5 sliding-window generator for the LeNet-5 first convolution layer. Accepts one raster-order pixel per valid cycle, keeps the four previous image rows in line buffers, and presents the full 25-pixel neighbourhood plus a qualifying strobe to the 5x5 conv engine directly downstream. Only fully-interior windows are flagged valid; there is no padding, so a 32x32 frame yields 28x28 = 784 windows.

## Interface
- IMAGE_COLS, 32, pixels per row (>= 5)
- IMAGE_ROWS, 32, rows per frame (>= 5)
- IN_WIDTH, 6, signed pixel width
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous and active-low
- pixel_valid  in  1  nextPixel/sof accepted this cycle when high
- sof  in  1  start of frame; qualified by pixel_valid
- nextPixel  in  IN_WIDTH  signed pixel, raster order
- win_flat  out  25*IN_WIDTH  window; element (r,c) at bits [(r*5+c)*IN_WIDTH +: IN_WIDTH]; r=0 oldest row, c=0 oldest column
- window_valid  out  1  win_flat holds a complete interior window
- frame_done  out  1  one-cycle pulse with the last pixel's window

## Operation
- Counters col (0..IMAGE_COLS-1) and row (0..IMAGE_ROWS-1) give the position of the next accepted pixel; both reset to 0.
- On an accepted pixel at (row, col):
  - Line buffers LB0..LB3, each IMAGE_COLS deep, cascaded. LB0 outputs pixel (row-1, col), LB1 (row-2, col), LB2 (row-3, col), LB3 (row-4, col).
  - New column vector = {LB3 out, LB2 out, LB1 out, LB0 out, nextPixel} for window rows 0..4.
  - The window shifts one column left (c=0 discarded), and the new column enters at c=4. Then nextPixel is pushed into LB0, and each LBk output is pushed into LBk+1.
  - col increments. At IMAGE_COLS-1, col wraps to 0 and row increments. At the last pixel, row wraps to 0.
- window_valid is registered high the cycle after acceptance iff row >= 4 and col >= 4 for that pixel; otherwise it is registered low.
- frame_done is registered high the cycle after acceptance of (IMAGE_ROWS-1, IMAGE_COLS-1).
- Cycles with pixel_valid low: window, counters and line buffers hold. window_valid and frame_done go low.
- sof with pixel_valid: that pixel is treated as (0,0) whatever the counter state. The counters restart, so the pixel's window_valid is 0.
  - Stale line-buffer and window contents are never flagged valid, because of the row/col gating.
- sof without pixel_valid is ignored.
- No stall/back-pressure. The consumer must accept every window_valid cycle.

## Timing
- Latency: 1 cycle from pixel acceptance to win_flat/window_valid update. win (4,4) equals the pixel accepted in the previous cycle.
- Throughput: 1 pixel/cycle. Back-to-back valid and arbitrary valid gaps are both supported.
- Reset values:
  - win_flat = 0, window_valid = 0, frame_done = 0.
  - col = row = 0.
  - Line-buffer contents are don't-care and are never exposed as valid.
- Reset asserted mid-frame: all outputs drop to 0 asynchronously. The next accepted pixel after release is (0,0), with or without sof.
- Consecutive frames: after frame_done, the next accepted pixel is (0,0) of the new frame with no bubble. First window_valid comes 4*IMAGE_COLS+4 accepted pixels later.
- Per frame, exactly (IMAGE_ROWS-4)*(IMAGE_COLS-4) window_valid pulses and exactly one frame_done.

## Test plan
- Reset, then a 32x32 frame with pixel = (row*32+col) mod 32 - 16, continuous valid.
  - Exactly 784 window_valid pulses; first after pixel 132 (row 4, col 4).
  - Every win (r,c) matches a golden 5x5 crop; frame_done coincides with the 784th pulse.
- Same frame with a pseudo-random 50% valid pattern.
  - Identical window sequence and count. window_valid is never high on cycles following an idle input cycle.
- Two back-to-back frames with different content: the second frame's first window contains only second-frame pixels, and there are 1568 pulses total.
- sof asserted at (10,7) mid-frame, then a full frame from that point: counters restart, the next 784 windows match the new frame, and there is no early pulse.
- rst pulled low for 1 cycle at (20,15), then a full frame: outputs read 0 during reset, then the full frame yields exactly 784 correct windows.
- Extreme values: all pixels -32 then all +31. Windows show sign-correct -32/+31, with no truncation across the IN_WIDTH fields.
